// File: rtl/ste_led_bar_pk.sv
// LED bar-graph driver: scales a sample to 0..LED_NR LEDs, bar or dot
// mode, with a peak-hold LED that decays on tick_i and PWM dimming.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   din_i        unsigned sample, valid when din_update_i = 1
//   din_update_i single-cycle strobe capturing din_i
//   clr_i        synchronous clear, same effect as reset
//   mode_i       0 = bar, 1 = dot
//   peak_en_i    show the peak-hold LED
//   tick_i       decay time base strobe
//   bright_i     brightness, 0 = off, >= 2^PWM_W = always on
//   led_o        registered LED drive, active high
module ste_led_bar_pk #(
    parameter int DATA_W     = 12,
    parameter int LED_NR     = 8,
    parameter int HOLD_TICKS = 8,
    parameter int PWM_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din_i,
    input  logic              din_update_i,
    input  logic              clr_i,
    input  logic              mode_i,
    input  logic              peak_en_i,
    input  logic              tick_i,
    input  logic [PWM_W:0]    bright_i,
    output logic [LED_NR-1:0] led_o
);

    localparam int LW = $clog2(LED_NR + 1);
    localparam int PW = DATA_W + LW;

    logic [LW-1:0]     lvl;
    logic [LW-1:0]     level_q;
    logic [LW-1:0]     peak_q;
    logic [LW-1:0]     level_new;
    logic [7:0]        hold_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              pwm_on;
    logic [LED_NR-1:0] pat;
    logic [LED_NR-1:0] pk;

    // Multiply by LED_NR+1 then drop DATA_W bits: full scale maps to
    // exactly LED_NR without needing a divider.
    assign lvl = LW'((PW'(din_i) * PW'(LED_NR + 1)) >> DATA_W);

    assign level_new = din_update_i ? lvl : level_q;

    assign pwm_on = ({1'b0, pwm_cnt} < bright_i);

    always_comb begin
        pat = '0;
        pk  = '0;
        for (int i = 0; i < LED_NR; i++) begin
            if (mode_i) begin
                pat[i] = (level_q != '0) && (i == int'(level_q) - 1);
            end else begin
                pat[i] = (i < int'(level_q));
            end
            pk[i] = peak_en_i && (peak_q != '0) && (i == int'(peak_q) - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            level_q  <= '0;
            peak_q   <= '0;
            hold_cnt <= '0;
            pwm_cnt  <= '0;
            led_o    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led_o   <= (pat | pk) & {LED_NR{pwm_on}};
            if (din_update_i) begin
                level_q <= lvl;
            end
            // A new higher-or-equal level restarts the hold and
            // swallows any tick arriving in the same cycle.
            if (din_update_i && (lvl >= peak_q)) begin
                peak_q   <= lvl;
                hold_cnt <= 8'(HOLD_TICKS);
            end else if (tick_i) begin
                if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - 1'b1;
                end else if (peak_q > level_new) begin
                    peak_q <= peak_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ste_led_bar_pk.md
Name: ste_led_bar_pk

Overview:
Parametrised LED bar-graph driver for the multimeter front panel, the next generation of the single-mode bar driver. It scales a sample to a 0..LED_NR level and drives a bar or single-dot display. It adds peak-hold with timed decay and PWM brightness control. It sits after the RMS/STE calculation block, takes its result on each update strobe, and drives the board LEDs directly.

Parameters:
DATA_W, 12, input sample width; full scale is 2^DATA_W-1.
LED_NR, 8, number of LEDs (2..32).
HOLD_TICKS, 8, number of tick_i pulses the peak is held before decay starts (1..255).
PWM_W, 4, PWM counter width; PWM period is 2^PWM_W clk cycles.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
din_i  in  DATA_W  unsigned input sample
din_update_i  in  1  single-cycle strobe; din_i is valid
clr_i  in  1  synchronous clear; same effect as reset
mode_i  in  1  0 = bar, 1 = dot
peak_en_i  in  1  1 = show the peak-hold LED
tick_i  in  1  single-cycle decay time base (e.g. 10 Hz strobe)
bright_i  in  PWM_W+1  brightness; 0 = off, >= 2^PWM_W = always on
led_o  out  LED_NR  LED drive, active high, registered

Behaviour:
- Clock and reset: clk rising edge; rst_n is synchronous and active-low. clr_i behaves identically and has priority over all other inputs.
- Reset/clear values: led_o = 0, level_q = 0, peak_q = 0, hold_cnt = 0, pwm_cnt = 0.
- Level scaling:
  - lvl = (din_i * (LED_NR+1)) >> DATA_W, range 0..LED_NR.
  - Product width is DATA_W + clog2(LED_NR+1); no overflow and no divider.
  - lvl is registered into level_q on the din_update_i edge. Without din_update_i, level_q holds.
- Peak hold (evaluated on the same edge, using the combinational lvl when din_update_i = 1):
  - If din_update_i and lvl >= peak_q: peak_q <= lvl, hold_cnt <= HOLD_TICKS. Any tick_i in that cycle is ignored.
  - Otherwise, if tick_i:
    - If hold_cnt > 0: hold_cnt decrements.
    - Else if peak_q > level_new: peak_q decrements by 1, where level_new is lvl if updating, else level_q.
  - peak_q never drops below level_q and never underflows.
- PWM:
  - pwm_cnt is a free-running PWM_W-bit wrap counter.
  - pwm_on = ({1'b0,pwm_cnt} < bright_i). bright_i = 0 gives never on; bright_i >= 2^PWM_W gives always on.
- Pattern (combinational from level_q, peak_q, mode_i, pwm_on):
  - Bar: pat[i] = (i < level_q).
  - Dot: pat[i] = (level_q > 0 && i == level_q-1).
  - Peak LED: pk[i] = peak_en_i && peak_q > 0 && i == peak_q-1.
  - Output: led_o <= (pat | pk) & {LED_NR{pwm_on}}. The peak LED is dimmed identically.
- Latency: din_update_i at edge N updates level_q/peak_q; led_o reflects them at edge N+1, i.e. 2 clocks from strobe to LED, subject to pwm_on.
- Boundaries:
  - din_i = 0 lights no LEDs.
  - din_i = 2^DATA_W-1 lights all LEDs.
  - Mode, peak_en_i and bright_i changes take effect at the next led_o register edge.
  - Reset or clear mid-hold drops the peak immediately; the next update restarts it.

Test Plan:
- Scaling (bright_i = 16, mode = bar, peak_en = 0, LED_NR = 8): din 0 -> led_o 0x00; din 2048 -> 0x0F; din 4095 -> 0xFF. Each appears 2 clk after the strobe.
- Dot mode: din 2048 with mode = 1 -> led_o 0x08; din 0 -> 0x00.
- Peak hold/decay (peak_en = 1, HOLD_TICKS = 3):
  - Update din 4095, then din 0 -> led_o 0x80.
  - After 3 ticks still 0x80; the 4th tick gives 0x40, and so on down to 0x00 after 8 post-hold ticks.
  - Extra ticks cause no underflow.
- Simultaneous update + tick:
  - With peak 6 and hold 0, update din giving lvl 7 together with tick -> peak 7, hold reloaded to HOLD_TICKS, no decrement.
  - With lvl 2 together with tick -> peak 5.
- PWM (PWM_W = 4, steady level 8):
  - bright_i = 4 -> led_o = 0xFF for exactly 4 of every 16 cycles.
  - bright_i = 0 -> always 0.
  - bright_i = 16 -> always 0xFF.
- Clear/reset: assert clr_i during hold with led_o = 0xFF -> next edge all state 0, led_o = 0x00. Same check for rst_n = 0 together with din_update_i: reset wins.
